// File: rtl/miriscv_arb_pkg.sv
// miriscv data-port arbiter: shared types and helpers.
// Master indices, request bundle and RAM range check.
package miriscv_arb_pkg;

    localparam int M_CORE    = 0;
    localparam int M_AUX     = 1;
    localparam int N_MASTERS = 2;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } arb_req_t;

    // 33-bit compare so base+size overflow cannot wrap into range
    function automatic logic in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] size
    );
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + size;
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/miriscv_rr_pick.sv
// miriscv data-port arbiter: two-way round-robin picker.
// On a tie the master that did not win last time is chosen.
module miriscv_rr_pick
    import miriscv_arb_pkg::*;
(
    input  logic [N_MASTERS-1:0] req,
    input  logic                 last,
    output logic [N_MASTERS-1:0] gnt
);

    // one-hot grant from the request pair and previous winner
    always_comb begin
        gnt = '0;
        unique case (1'b1)
            (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
            (req == 2'b01): gnt = 2'b01;
            (req == 2'b10): gnt = 2'b10;
            default:        gnt = '0;
        endcase
    end

endmodule

// File: rtl/miriscv_data_arbiter.sv
// miriscv data-port arbiter: shares the RAM data port
// between the LSU (m0) and an auxiliary master (m1).
module miriscv_data_arbiter
    import miriscv_arb_pkg::*;
#(
    parameter int unsigned RAM_SIZE  = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        arstn_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);

    localparam logic [32:0] SIZE33 = 33'(RAM_SIZE);

    arb_req_t             m_req [N_MASTERS];
    logic [N_MASTERS-1:0] req_v;
    logic [N_MASTERS-1:0] gnt_v;
    logic                 any_gnt;
    logic                 winner;
    arb_req_t             sel;
    logic                 hit;

    logic                 busy_q;
    logic                 owner_q;
    logic                 we_q;
    logic                 err_q;
    logic                 last_q;
    logic [31:0]          rsp_rdata;

    assign m_req[M_CORE] = '{
        we: m0_we_i, be: m0_be_i,
        addr: m0_addr_i, wdata: m0_wdata_i
    };
    assign m_req[M_AUX] = '{
        we: m1_we_i, be: m1_be_i,
        addr: m1_addr_i, wdata: m1_wdata_i
    };

    assign req_v = {m1_req_i, m0_req_i};

    miriscv_rr_pick u_pick (
        .req  (req_v),
        .last (last_q),
        .gnt  (gnt_v)
    );

    assign any_gnt  = |gnt_v;
    assign winner   = gnt_v[M_AUX];
    assign sel      = winner ? m_req[M_AUX] : m_req[M_CORE];
    assign hit      = in_range(sel.addr, BASE_ADDR, SIZE33);

    assign m0_gnt_o = gnt_v[M_CORE];
    assign m1_gnt_o = gnt_v[M_AUX];

    assign ram_req_o   = any_gnt & hit;
    assign ram_we_o    = any_gnt & sel.we;
    assign ram_be_o    = any_gnt ? sel.be : 4'h0;
    assign ram_addr_o  = any_gnt ? (sel.addr - BASE_ADDR) : 32'h0;
    assign ram_wdata_o = any_gnt ? sel.wdata : 32'h0;

    // response tracking: one outstanding access, owner and kind
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            busy_q <= any_gnt;
            if (any_gnt) begin
                owner_q <= winner;
                we_q    <= sel.we;
                err_q   <= ~hit;
                last_q  <= winner;
            end
        end
    end

    assign rsp_rdata   = (~we_q & ~err_q) ? ram_rdata_i : 32'h0;

    assign m0_rvalid_o = busy_q & ~owner_q;
    assign m1_rvalid_o = busy_q & owner_q;
    assign m0_rdata_o  = m0_rvalid_o ? rsp_rdata : 32'h0;
    assign m1_rdata_o  = m1_rvalid_o ? rsp_rdata : 32'h0;
    assign m0_err_o    = m0_rvalid_o & err_q;
    assign m1_err_o    = m1_rvalid_o & err_q;

endmodule
